// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared raster timing definitions for the video pipeline.
// Holds the default 640x480@60 timing constants, the derived line/frame
// totals, the coordinate width every pixel-rate block agrees on, and a
// small window-decode helper used for sync and active-video decoding.
// No ports (package).

package vga_timing_pkg;

    localparam int COORD_W   = 10;
    localparam int MAX_TOTAL = 1 << COORD_W;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef logic [COORD_W-1:0] coord_t;

    // True when start <= pos < start+width. Done in int so a window that
    // ends exactly at 1024 cannot overflow the 10-bit coordinate.
    function automatic logic in_window(input coord_t pos, input int start, input int width);
        int p;
        p = {{(32-COORD_W){1'b0}}, pos};
        return (p >= start) && (p < start + width);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// pixel_tick_gen
// Divides the system clock down to a pixel-rate enable.
// A counter runs 0..CLK_DIV-1 on every clk; pix_tick is registered and is
// high for exactly one clk each time the counter wraps. With CLK_DIV=1 the
// counter never moves and pix_tick is high on every clk after reset.
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-low reset
//   pix_tick out  one-clk pixel enable

module pixel_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic pix_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_div_check
        $error("pixel_tick_gen: CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0] div;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div      <= '0;
            pix_tick <= 1'b0;
        end else begin
            if (div == DIV_LAST) begin
                div <= '0;
            end else begin
                div <= div + DIV_W'(1);
            end
            pix_tick <= (div == DIV_LAST);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing generator feeding the sprite renderers. Produces the pixel
// coordinates, hsync/vsync, an active-video flag and frame bookkeeping.
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous active-low reset
//   x, y        out  current column / line (10 bit)
//   hsync/vsync out  sync strobes, asserted level = SYNC_POL
//   active      out  high inside the visible area
//   pix_tick    out  one-clk pixel enable; counters advance on it
//   frame_start out  one-clk pulse when (x,y) wraps to (0,0)
//   frame_count out  frames completed since reset (wraps at 2^16)

module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CLK_DIV  = 2,
    parameter int SYNC_POL = 0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic               pix_tick,
    output logic               frame_start,
    output logic [15:0]        frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the coordinate range");
    end

    localparam coord_t X_LAST   = COORD_W'(H_TOTAL - 1);
    localparam coord_t Y_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic   SYNC_ON  = (SYNC_POL != 0);
    localparam logic   SYNC_OFF = !SYNC_ON;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .pix_tick (pix_tick)
    );

    coord_t      x_next;
    coord_t      y_next;
    logic        frame_wrap;
    logic [15:0] count_next;

    // Next raster position. Sync and active are decoded from this rather
    // than from the current registers so they land in the same clk as x/y.
    always_comb begin
        x_next     = x;
        y_next     = y;
        frame_wrap = 1'b0;
        if (pix_tick) begin
            if (x != X_LAST) begin
                x_next = x + COORD_W'(1);
            end else begin
                x_next = '0;
                if (y != Y_LAST) begin
                    y_next = y + COORD_W'(1);
                end else begin
                    y_next     = '0;
                    frame_wrap = 1'b1;
                end
            end
        end
        count_next = frame_wrap ? frame_count + 16'd1 : frame_count;
    end

    // Every register reloads on every clk; between ticks the next values
    // equal the current ones, so outputs simply hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x           <= '0;
            y           <= '0;
            frame_count <= '0;
            frame_start <= 1'b0;
            hsync       <= SYNC_OFF;
            vsync       <= SYNC_OFF;
            active      <= 1'b1;
        end else begin
            x           <= x_next;
            y           <= y_next;
            frame_count <= count_next;
            frame_start <= frame_wrap;
            hsync       <= in_window(x_next, H_ACTIVE + H_FP, H_SYNC) ? SYNC_ON : SYNC_OFF;
            vsync       <= in_window(y_next, V_ACTIVE + V_FP, V_SYNC) ? SYNC_ON : SYNC_OFF;
            active      <= in_window(x_next, 0, H_ACTIVE) && in_window(y_next, 0, V_ACTIVE);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Self-checking bench for vga_timing_gen. Two instances share one clock:
// dut_d with default 640x480 timing and dut_s with a tiny 8x6 raster,
// CLK_DIV=1 and active-high sync. A behavioural model of each instance is
// stepped on every clock edge; the selected instance's expected outputs are
// pushed to a queue and popped at the following negedge for comparison.
// Ports: none.

module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               hs;
        logic               vs;
        logic               act;
        logic               pt;
        logic               fs;
        logic [15:0]        fc;
    } rec_t;

    typedef struct {
        int   ha, hf, hsw, hb, va, vf, vsw, vb, cdiv;
        logic pol;
    } cfg_t;

    typedef struct {
        int          div;
        logic        pt;
        int          x, y;
        logic [15:0] fc;
        logic        fs, hs, vs, act;
    } mstate_t;

    localparam cfg_t CFG_D = '{DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP,
                               DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP, 2, 1'b0};
    localparam cfg_t CFG_S = '{4, 1, 2, 1, 3, 1, 1, 1, 1, 1'b1};

    localparam rec_t RESET_D = '{x: '0, y: '0, hs: 1'b1, vs: 1'b1, act: 1'b1,
                                 pt: 1'b0, fs: 1'b0, fc: 16'd0};
    localparam rec_t RESET_S = '{x: '0, y: '0, hs: 1'b0, vs: 1'b0, act: 1'b1,
                                 pt: 1'b0, fs: 1'b0, fc: 16'd0};

    logic clk;
    logic rst_d, rst_s;

    logic [COORD_W-1:0] d_x, d_y, s_x, s_y;
    logic               d_hs, d_vs, d_act, d_pt, d_fs;
    logic               s_hs, s_vs, s_act, s_pt, s_fs;
    logic [15:0]        d_fc, s_fc;
    rec_t               obs_d, obs_s;

    assign obs_d = {d_x, d_y, d_hs, d_vs, d_act, d_pt, d_fs, d_fc};
    assign obs_s = {s_x, s_y, s_hs, s_vs, s_act, s_pt, s_fs, s_fc};

    int      total;
    int      bad;
    int      sel;
    mstate_t m_d, m_s;
    rec_t    q_d[$];
    rec_t    q_s[$];

    vga_timing_gen dut_d (
        .clk         (clk),
        .reset       (rst_d),
        .x           (d_x),
        .y           (d_y),
        .hsync       (d_hs),
        .vsync       (d_vs),
        .active      (d_act),
        .pix_tick    (d_pt),
        .frame_start (d_fs),
        .frame_count (d_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .CLK_DIV  (1), .SYNC_POL (1)
    ) dut_s (
        .clk         (clk),
        .reset       (rst_s),
        .x           (s_x),
        .y           (s_y),
        .hsync       (s_hs),
        .vsync       (s_vs),
        .active      (s_act),
        .pix_tick    (s_pt),
        .frame_start (s_fs),
        .frame_count (s_fc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mstate_t model_reset(input cfg_t c);
        mstate_t n;
        n.div = 0; n.pt = 1'b0; n.x = 0; n.y = 0; n.fc = 16'd0; n.fs = 1'b0;
        n.hs = !c.pol; n.vs = !c.pol; n.act = 1'b1;
        return n;
    endfunction

    // One clk of the reference raster, written from the timing description.
    function automatic mstate_t model_step(input mstate_t s, input cfg_t c, input logic rn);
        mstate_t n;
        int      htot, vtot;
        if (!rn) return model_reset(c);
        htot  = c.ha + c.hf + c.hsw + c.hb;
        vtot  = c.va + c.vf + c.vsw + c.vb;
        n     = s;
        n.div = (s.div + 1) % c.cdiv;
        n.pt  = (s.div == c.cdiv - 1);
        n.fs  = 1'b0;
        if (s.pt) begin
            n.x = (s.x + 1) % htot;
            if (n.x == 0) begin
                n.y = (s.y + 1) % vtot;
                if (n.y == 0) begin
                    n.fc = s.fc + 16'd1;
                    n.fs = 1'b1;
                end
            end
        end
        n.hs  = (n.x >= c.ha + c.hf && n.x < c.ha + c.hf + c.hsw) ? c.pol : !c.pol;
        n.vs  = (n.y >= c.va + c.vf && n.y < c.va + c.vf + c.vsw) ? c.pol : !c.pol;
        n.act = (n.x < c.ha) && (n.y < c.va);
        return n;
    endfunction

    function automatic rec_t to_rec(input mstate_t s);
        rec_t r;
        r.x = 10'(s.x); r.y = 10'(s.y);
        r.hs = s.hs; r.vs = s.vs; r.act = s.act; r.pt = s.pt; r.fs = s.fs; r.fc = s.fc;
        return r;
    endfunction

    // Advance one clk: step both models at the edge, queue the selected
    // instance's expectation, and return at the following negedge.
    task automatic tick_clk();
        @(posedge clk);
        m_d = model_step(m_d, CFG_D, rst_d);
        m_s = model_step(m_s, CFG_S, rst_s);
        if (sel == 0) q_d.push_back(to_rec(m_d));
        else          q_s.push_back(to_rec(m_s));
        @(negedge clk);
    endtask

    task automatic test_reset();
        rec_t e;
        int   ticks;
        sel = 0;
        for (int i = 0; i < 3; i++) begin
            tick_clk();
            e = q_d.pop_front();
            total++;
            if (obs_d !== e) begin
                bad++;
                $display("[TB] FAIL reset_model: got %h want %h", obs_d, e);
            end
            total++;
            if (obs_d !== RESET_D) begin
                bad++;
                $display("[TB] FAIL reset_value: got %h want %h", obs_d, RESET_D);
            end
        end
        rst_d = 1'b1;
        rst_s = 1'b1;
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            tick_clk();
            e = q_d.pop_front();
            total++;
            if (obs_d !== e) begin
                bad++;
                $display("[TB] FAIL release_seq: got %h want %h", obs_d, e);
            end
            if (d_pt === 1'b1) ticks++;
        end
        total++;
        if (ticks != 4) begin
            bad++;
            $display("[TB] FAIL pix_tick_rate: got %0d want 4", ticks);
        end
    endtask

    task automatic test_line_timing();
        rec_t e;
        int   hs_low, act_low;
        sel = 0;
        hs_low = 0;
        act_low = 0;
        for (int i = 0; i < 1600; i++) begin
            tick_clk();
            e = q_d.pop_front();
            total++;
            if (obs_d !== e) begin
                bad++;
                $display("[TB] FAIL line_rec: got %h want %h", obs_d, e);
            end
            if (d_hs === 1'b0) hs_low++;
            if (d_act === 1'b0) act_low++;
        end
        total++;
        if (hs_low != 192) begin
            bad++;
            $display("[TB] FAIL hsync_width: got %0d clks want 192", hs_low);
        end
        total++;
        if (act_low != 320) begin
            bad++;
            $display("[TB] FAIL hblank_width: got %0d clks want 320", act_low);
        end
        total++;
        if (d_x !== 10'd3 || d_y !== 10'd1) begin
            bad++;
            $display("[TB] FAIL line_advance: got (%0d,%0d) want (3,1)", d_x, d_y);
        end
    endtask

    task automatic test_frame_wrap();
        rec_t e;
        int   vs_low, fs_cnt, n;
        sel = 0;
        n = 0;
        while (d_pt !== 1'b0 && n < 4) begin
            tick_clk();
            void'(q_d.pop_front());
            n++;
        end
        total++;
        if (d_pt !== 1'b0) begin
            bad++;
            $display("[TB] FAIL tick_phase_wait: got pix_tick=%b want 0", d_pt);
        end
        // Jump to the line before vsync by holding x/y over a non-tick edge.
        force dut_d.x = 10'd0;
        force dut_d.y = 10'd489;
        m_d.x = 0;
        m_d.y = 489;
        tick_clk();
        release dut_d.x;
        release dut_d.y;
        void'(q_d.pop_front());
        vs_low = 0;
        for (int i = 0; i < 4800; i++) begin
            tick_clk();
            e = q_d.pop_front();
            total++;
            if (obs_d !== e) begin
                bad++;
                $display("[TB] FAIL vsync_rec: got %h want %h", obs_d, e);
            end
            if (d_vs === 1'b0) vs_low++;
        end
        total++;
        if (vs_low != 3200) begin
            bad++;
            $display("[TB] FAIL vsync_width: got %0d clks want 3200", vs_low);
        end
        n = 0;
        while (d_pt !== 1'b0 && n < 4) begin
            tick_clk();
            void'(q_d.pop_front());
            n++;
        end
        force dut_d.x = 10'd795;
        force dut_d.y = 10'd524;
        m_d.x = 795;
        m_d.y = 524;
        tick_clk();
        release dut_d.x;
        release dut_d.y;
        void'(q_d.pop_front());
        fs_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick_clk();
            e = q_d.pop_front();
            total++;
            if (obs_d !== e) begin
                bad++;
                $display("[TB] FAIL wrap_rec: got %h want %h", obs_d, e);
            end
            if (d_fs === 1'b1) begin
                fs_cnt++;
                total++;
                if (d_x !== 10'd0 || d_y !== 10'd0) begin
                    bad++;
                    $display("[TB] FAIL frame_start_pos: got (%0d,%0d) want (0,0)", d_x, d_y);
                end
            end
        end
        total++;
        if (fs_cnt != 1 || d_fc !== 16'd1) begin
            bad++;
            $display("[TB] FAIL frame_wrap: got pulses=%0d count=%0d want 1/1", fs_cnt, d_fc);
        end
    endtask

    task automatic test_async_reset();
        rec_t e;
        int   n, fs_cnt;
        sel = 0;
        n = 0;
        while (d_pt !== 1'b0 && n < 4) begin
            tick_clk();
            void'(q_d.pop_front());
            n++;
        end
        force dut_d.x = 10'd300;
        force dut_d.y = 10'd200;
        m_d.x = 300;
        m_d.y = 200;
        tick_clk();
        release dut_d.x;
        release dut_d.y;
        void'(q_d.pop_front());
        for (int i = 0; i < 4; i++) begin
            tick_clk();
            e = q_d.pop_front();
            total++;
            if (obs_d !== e) begin
                bad++;
                $display("[TB] FAIL midframe_rec: got %h want %h", obs_d, e);
            end
        end
        #2;
        rst_d = 1'b0;
        #1;
        total++;
        if (obs_d !== RESET_D) begin
            bad++;
            $display("[TB] FAIL async_clear: got %h want %h", obs_d, RESET_D);
        end
        tick_clk();
        e = q_d.pop_front();
        total++;
        if (obs_d !== e) begin
            bad++;
            $display("[TB] FAIL held_reset: got %h want %h", obs_d, e);
        end
        rst_d = 1'b1;
        fs_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick_clk();
            e = q_d.pop_front();
            total++;
            if (obs_d !== e) begin
                bad++;
                $display("[TB] FAIL restart_rec: got %h want %h", obs_d, e);
            end
            if (d_fs === 1'b1) fs_cnt++;
            if (i == 2) begin
                total++;
                if (d_x !== 10'd1 || d_y !== 10'd0) begin
                    bad++;
                    $display("[TB] FAIL first_tick: got (%0d,%0d) want (1,0)", d_x, d_y);
                end
            end
        end
        total++;
        if (fs_cnt != 0) begin
            bad++;
            $display("[TB] FAIL spurious_frame_start: got %0d pulses want 0", fs_cnt);
        end
    endtask

    task automatic test_small_frame();
        rec_t e;
        int   fs_cnt, ex, ey;
        sel = 1;
        rst_s = 1'b0;
        tick_clk();
        e = q_s.pop_front();
        total++;
        if (obs_s !== RESET_S || obs_s !== e) begin
            bad++;
            $display("[TB] FAIL small_reset: got %h want %h", obs_s, RESET_S);
        end
        rst_s = 1'b1;
        fs_cnt = 0;
        for (int k = 1; k <= 145; k++) begin
            tick_clk();
            e = q_s.pop_front();
            total++;
            if (obs_s !== e) begin
                bad++;
                $display("[TB] FAIL small_rec: k=%0d got %h want %h", k, obs_s, e);
            end
            ex = (k - 1) % 8;
            ey = ((k - 1) / 8) % 6;
            total++;
            if (s_x !== 10'(ex) || s_y !== 10'(ey)) begin
                bad++;
                $display("[TB] FAIL small_xy: k=%0d got (%0d,%0d) want (%0d,%0d)", k, s_x, s_y, ex, ey);
            end
            if (s_fs === 1'b1) fs_cnt++;
        end
        total++;
        if (fs_cnt != 3 || s_fc !== 16'd3) begin
            bad++;
            $display("[TB] FAIL small_frames: got pulses=%0d count=%0d want 3/3", fs_cnt, s_fc);
        end
    endtask

    task automatic test_count_wrap();
        rec_t e;
        int   fs_cnt;
        sel = 1;
        // Held across an edge with no frame wrap, so the register reloads
        // the forced value and keeps it after release.
        force dut_s.frame_count = 16'hFFFF;
        m_s.fc = 16'hFFFF;
        tick_clk();
        release dut_s.frame_count;
        e = q_s.pop_front();
        total++;
        if (obs_s !== e) begin
            bad++;
            $display("[TB] FAIL preload: got %h want %h", obs_s, e);
        end
        fs_cnt = 0;
        for (int i = 0; i < 48; i++) begin
            tick_clk();
            e = q_s.pop_front();
            total++;
            if (obs_s !== e) begin
                bad++;
                $display("[TB] FAIL count_wrap_rec: got %h want %h", obs_s, e);
            end
            if (s_fs === 1'b1) fs_cnt++;
        end
        total++;
        if (fs_cnt != 1 || s_fc !== 16'd0) begin
            bad++;
            $display("[TB] FAIL count_wrap: got pulses=%0d count=%0d want 1/0", fs_cnt, s_fc);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        sel   = 0;
        rst_d = 1'b0;
        rst_s = 1'b0;
        m_d   = model_reset(CFG_D);
        m_s   = model_reset(CFG_S);
        test_reset();
        test_line_timing();
        test_frame_wrap();
        test_async_reset();
        test_small_frame();
        test_count_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
